// File: rtl/lcd_hd44780_responder_if.sv
// LCD character-bus bundle between the controller (master) and the display (slave).
// Latency: none, wires only.
// Backpressure: none; the slave signals busy through the status read.
interface lcd_hd44780_responder_if;
  logic       iLCD_EN;
  logic       iLCD_RS;
  logic       iLCD_RW;
  logic [7:0] iLCD_DATA;
  logic [7:0] oLCD_DATA;
  logic       oLCD_DATA_OE;

  modport master (
    output iLCD_EN, iLCD_RS, iLCD_RW, iLCD_DATA,
    input  oLCD_DATA, oLCD_DATA_OE
  );

  modport slave (
    input  iLCD_EN, iLCD_RS, iLCD_RW, iLCD_DATA,
    output oLCD_DATA, oLCD_DATA_OE
  );
endinterface

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible display-side responder with a 32-character visible DDRAM image.
// Latency: state update and oWR_STB two cycles after EN is first sampled low; OE lags EN by two cycles.
// Backpressure: writes while busy are dropped and flag oERR; busy logic exists only with LCD_RESP_BUSY_EN.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  lcd_hd44780_responder_if.slave lcd,
  output logic [255:0]         oFB,
  output logic [6:0]           oAC,
  output logic                 oDISP_ON,
  output logic                 oBUSY,
  output logic                 oWR_STB,
  output logic                 oERR
);

  // Synchronizer stages and EN history for falling-edge detection
  logic       en_s1, en_s2, en_prev;
  logic       rs_s1, rs_s2;
  logic       rw_s1, rw_s2;
  logic [7:0] data_s1, data_s2;

  // Architectural state
  logic [6:0] ac;
  logic       id;
  logic       disp;
  logic       err;
  logic       stb;
  logic [7:0] fb [32];
  logic [7:0] rd_dat;
  logic       rd_oe;

  // Next-state values from the decoder
  logic [6:0]  ac_n;
  logic        id_n;
  logic        disp_n;
  logic        err_n;
  logic        stb_n;
  logic        fb_clr;
  logic        fb_we;
  logic [4:0]  fb_widx;
  logic [7:0]  fb_wdat;
  logic [31:0] busy_load;
  logic        busy_now;
  logic        fall;
  logic [7:0]  char_at_ac;

  // Address counter walks 0x00-0x27 and 0x40-0x67, wrapping between the two lines.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h40)      r = 7'h27;
      else if (a == 7'h00) r = 7'h67;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic ac_valid(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Only the first 16 columns of each line are on the glass.
  function automatic logic ac_visible(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  function automatic logic [4:0] ac_idx(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // Two-flop synchronizer on all bus inputs plus one extra EN stage
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      en_prev <= 1'b0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      rw_s1   <= 1'b0;
      rw_s2   <= 1'b0;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
    end else begin
      en_s1   <= lcd.iLCD_EN;
      en_s2   <= en_s1;
      en_prev <= en_s2;
      rs_s1   <= lcd.iLCD_RS;
      rs_s2   <= rs_s1;
      rw_s1   <= lcd.iLCD_RW;
      rw_s2   <= rw_s1;
      data_s1 <= lcd.iLCD_DATA;
      data_s2 <= data_s1;
    end
  end

  assign fall       = en_prev & ~en_s2;
  assign char_at_ac = ac_visible(ac) ? fb[ac_idx(ac)] : 8'h20;

  // Decode the transaction completed by an EN falling edge
  always_comb begin
    ac_n      = ac;
    id_n      = id;
    disp_n    = disp;
    err_n     = err;
    stb_n     = 1'b0;
    fb_clr    = 1'b0;
    fb_we     = 1'b0;
    fb_widx   = ac_idx(ac);
    fb_wdat   = data_s2;
    busy_load = 32'(BUSY_CYCLES);
    if (fall) begin
      if (rw_s2) begin
        // Data reads auto-step the counter; status reads are side-effect free.
        if (rs_s2) ac_n = ac_step(ac, id);
      end else if (rs_s2 || (data_s2 != 8'h00)) begin
        if (busy_now) begin
          err_n = 1'b1;
        end else begin
          stb_n = 1'b1;
          if (rs_s2) begin
            fb_we = ac_visible(ac);
            ac_n  = ac_step(ac, id);
          end else begin
            casez (data_s2)
              8'b1???????: begin
                ac_n = data_s2[6:0];
                if (!ac_valid(data_s2[6:0])) err_n = 1'b1;
              end
              8'b01??????: ;
              8'b001?????: begin
                // Only the 8-bit interface is modelled.
                if (!data_s2[4]) err_n = 1'b1;
              end
              8'b0001????: ;
              8'b00001???: disp_n = data_s2[2];
              8'b000001??: id_n = data_s2[1];
              8'b0000001?: ac_n = 7'h00;
              default: begin
                fb_clr    = 1'b1;
                ac_n      = 7'h00;
                id_n      = 1'b1;
                busy_load = 32'(CLEAR_CYCLES);
              end
            endcase
          end
        end
      end
    end
  end

  // Control state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ac   <= 7'h00;
      id   <= 1'b1;
      disp <= 1'b0;
      err  <= 1'b0;
      stb  <= 1'b0;
    end else begin
      ac   <= ac_n;
      id   <= id_n;
      disp <= disp_n;
      err  <= err_n;
      stb  <= stb_n;
    end
  end

  // Visible character image
  always_ff @(posedge iCLK) begin
    if (iRST || fb_clr) begin
      for (int i = 0; i < 32; i++) fb[i] <= 8'h20;
    end else if (fb_we) begin
      fb[fb_widx] <= fb_wdat;
    end
  end

  // Read-back driver, registered so OE follows the synchronized EN by one more cycle
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rd_oe  <= 1'b0;
      rd_dat <= 8'h00;
    end else begin
      rd_oe  <= en_s2 & rw_s2;
      if (en_s2 && rw_s2) rd_dat <= rs_s2 ? char_at_ac : {busy_now, ac};
      else                rd_dat <= 8'h00;
    end
  end

`ifdef LCD_RESP_BUSY_EN
  logic [31:0] busy_cnt;

  // Busy countdown, reloaded by each accepted write
  always_ff @(posedge iCLK) begin
    if (iRST)                  busy_cnt <= 32'd0;
    else if (stb_n)            busy_cnt <= busy_load;
    else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 32'd1;
  end

  assign busy_now = (busy_cnt != 32'd0);
`else
  logic unused_busy_load;

  assign unused_busy_load = ^busy_load;
  assign busy_now         = 1'b0;
`endif

  for (genvar g = 0; g < 32; g++) begin : g_fb
    assign oFB[8*g +: 8] = fb[g];
  end

  assign oAC              = ac;
  assign oDISP_ON         = disp;
  assign oBUSY            = busy_now;
  assign oWR_STB          = stb;
  assign oERR             = err;
  assign lcd.oLCD_DATA    = rd_dat;
  assign lcd.oLCD_DATA_OE = rd_oe;

endmodule
